nibble_serializer: RTL and testbench
====================================

NIBBLE_SERIALIZER -- requirements
Module: nibble_serializer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the parallel word width in bits (legal range 2..16).
REQ-002 The block SHALL take parameter LSB_FIRST, default 1, where 1 shifts out bit 0 first and 0 shifts out bit WIDTH-1 first.
REQ-003 clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream word on in_data is valid.
REQ-006 in_data  input  WIDTH  parallel word from the upstream buffer register.
REQ-007 in_ready  output  1  block accepts a word at this edge if in_valid is also 1.
REQ-008 sout  output  1  registered serial data bit.
REQ-009 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-010 frame_start  output  1  one-cycle pulse coincident with the first data bit of a frame.
REQ-011 frame_done  output  1  one-cycle pulse coincident with the last bit of a frame (last data bit, or parity bit when enabled).
REQ-012 busy  output  1  high while state is not IDLE.

Function
REQ-013 Handshake: a word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; there are no other accept conditions.
REQ-014 FSM states: IDLE, SHIFT, and PAR (PAR present only with PARITY_EN); IDLE->SHIFT on accept; SHIFT->SHIFT while bit count < WIDTH-1; the last SHIFT bit goes to PAR (parity on), to SHIFT (accept), or to IDLE (no accept); PAR goes to SHIFT (accept) or IDLE.
REQ-015 On the accept edge, the shift register SHALL load in_data and sout SHALL take the first bit per LSB_FIRST, with sout_valid=1 and frame_start=1 in the following cycle (latency 1 cycle).
REQ-016 Each subsequent edge in SHIFT SHALL advance one bit; a frame SHALL occupy exactly WIDTH consecutive sout_valid cycles, plus 1 with PARITY_EN.
REQ-017 in_ready SHALL be 1 in IDLE and during the final bit cycle of a frame; otherwise it SHALL be 0 and in_data is ignored.
REQ-018 A back-to-back accept in the final bit cycle SHALL start the next frame on the very next cycle with no idle gap; frame_done and the next frame_start SHALL then appear in adjacent cycles.
REQ-019 In IDLE, sout SHALL be 0, and sout_valid, frame_start and frame_done SHALL be 0.
REQ-020 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, reset to 0 on every accept, and never wrap inside a frame.
REQ-021 in_valid held high while busy SHALL NOT corrupt the frame in flight.

Reset
REQ-022 While reset=1 at an edge: state SHALL go to IDLE, the counter and shift register SHALL clear, and sout, sout_valid, frame_start, frame_done and busy SHALL be 0.
REQ-023 in_ready SHALL be forced to 0 in any cycle where reset=1, so no word is accepted on a reset edge.
REQ-024 A reset mid-frame SHALL abort the frame with no frame_done; outputs SHALL be 0 in the next cycle.

Configuration
REQ-025 Macro NIBBLE_SERIALIZER_PARITY_EN: when defined, one even-parity bit (XOR of all WIDTH data bits) SHALL follow the data in state PAR with sout_valid=1 and frame_done=1.
REQ-026 When NIBBLE_SERIALIZER_PARITY_EN is undefined, PAR logic SHALL be absent and frame_done SHALL coincide with the last data bit.

Verification
REQ-027 WIDTH=4, LSB_FIRST=1, no parity, accept in_data=4'b1011 -> sout=1,1,0,1 on 4 consecutive cycles; frame_start on cycle 1; frame_done on cycle 4; then IDLE.
REQ-028 Same word with NIBBLE_SERIALIZER_PARITY_EN -> sout=1,1,0,1,1; frame_done on the parity cycle (5th).
REQ-029 LSB_FIRST=0, in_data=4'b1000 -> sout=1,0,0,0.
REQ-030 Back-to-back: 4'b0001 then 4'b1110, with the second accepted in the final bit cycle -> 8 contiguous sout_valid cycles with sout=1,0,0,0,0,1,1,1 and no gap.
REQ-031 in_valid held high with changing in_data during frame 4'b0101 -> output stays 1,0,1,0; in_ready=0 on cycles 1-3.
REQ-032 reset=1 on the 2nd bit of frame 4'b1111 -> the next cycle has sout=0, sout_valid=0, busy=0, and no frame_done pulse.

Source files
------------

// File: rtl/nibble_serializer.sv
// nibble_serializer: parallel word to serial bit stream, valid/ready input
// side, registered serial output with frame_start/frame_done pulses.
// Ports: clock, reset (sync, active-high), in_valid, in_data[WIDTH],
//   in_ready, sout, sout_valid, frame_start, frame_done, busy.
// Optional even-parity trailer bit: define NIBBLE_SERIALIZER_PARITY_EN.
module nibble_serializer #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENU = CW'(WIDTH - 2);

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic             sout_n, sv_n, fs_n, fd_n;
  logic             last, accept;

`ifdef NIBBLE_SERIALIZER_PARITY_EN
  logic par, par_n;
  assign last = (state == PAR);
`else
  assign last = (state == SHIFT) && (cnt == LAST);
`endif

  // Ready in IDLE or while the final frame bit is on sout,
  // which lets the next frame follow with no gap.
  assign in_ready = !reset && ((state == IDLE) || last);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    sout_n  = 1'b0;
    sv_n    = 1'b0;
    fs_n    = 1'b0;
    fd_n    = 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    if (accept) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sh_n    = in_data;
      sout_n  = (LSB_FIRST != 0) ? in_data[0] : in_data[WIDTH-1];
      sv_n    = 1'b1;
      fs_n    = 1'b1;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      par_n   = ^in_data;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state_n = IDLE;
        end
        SHIFT: begin
          if (cnt != LAST) begin
            cnt_n  = cnt + CW'(1);
            sh_n   = (LSB_FIRST != 0) ? (sh >> 1) : (sh << 1);
            sout_n = (LSB_FIRST != 0) ? sh_n[0] : sh_n[WIDTH-1];
            sv_n   = 1'b1;
`ifndef NIBBLE_SERIALIZER_PARITY_EN
            fd_n   = (cnt == PENU);
`endif
          end else begin
`ifdef NIBBLE_SERIALIZER_PARITY_EN
            state_n = PAR;
            sout_n  = par;
            sv_n    = 1'b1;
            fd_n    = 1'b1;
`else
            state_n = IDLE;
`endif
          end
        end
`ifdef NIBBLE_SERIALIZER_PARITY_EN
        PAR: begin
          state_n = IDLE;
        end
`endif
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sh          <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sh          <= sh_n;
      sout        <= sout_n;
      sout_valid  <= sv_n;
      frame_start <= fs_n;
      frame_done  <= fd_n;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
      par         <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// tb_nibble_serializer: scoreboard bench, LSB-first and MSB-first
// instances driven in parallel from one valid/ready stimulus stream.
module tb_nibble_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;

  logic r0, s0, v0, fs0, fd0, b0;
  logic r1, s1, v1, fs1, fd1, b1;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  bit run = 1'b0;

  // entries: {sout, frame_start, frame_done}
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clock = ~clock;

  nibble_serializer #(.WIDTH(4), .LSB_FIRST(1)) u_lsb (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r0),
    .sout(s0), .sout_valid(v0), .frame_start(fs0),
    .frame_done(fd0), .busy(b0)
  );

  nibble_serializer #(.WIDTH(4), .LSB_FIRST(0)) u_msb (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(r1),
    .sout(s1), .sout_valid(v1), .frame_start(fs1),
    .frame_done(fd1), .busy(b1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  bit par_on;
`ifdef NIBBLE_SERIALIZER_PARITY_EN
  initial par_on = 1'b1;
`else
  initial par_on = 1'b0;
`endif

  // Model of accept: ready when no frame bits remain queued.
  always @(posedge clock) begin
    if (reset) begin
      q0.delete();
      q1.delete();
    end else if (in_valid && q0.size() == 0) begin
      for (int i = 0; i < 4; i++) begin
        logic l;
        l = (i == 3) && !par_on;
        q0.push_back({in_data[i], i == 0, l});
        q1.push_back({in_data[3-i], i == 0, l});
      end
      if (par_on) begin
        q0.push_back({^in_data, 1'b0, 1'b1});
        q1.push_back({^in_data, 1'b0, 1'b1});
      end
      acc_cnt++;
    end
  end

  always @(negedge clock) begin
    if (run) begin
      logic [2:0] e;
      logic ev;
      ev = (q0.size() != 0);
      chk("lsb_valid", v0, ev);
      chk("lsb_busy", b0, ev);
      e = ev ? q0.pop_front() : 3'b000;
      chk("lsb_sout", s0, e[2]);
      chk("lsb_fstart", fs0, e[1]);
      chk("lsb_fdone", fd0, e[0]);
      chk("lsb_ready", r0, !reset && q0.size() == 0);
      ev = (q1.size() != 0);
      chk("msb_valid", v1, ev);
      chk("msb_busy", b1, ev);
      e = ev ? q1.pop_front() : 3'b000;
      chk("msb_sout", s1, e[2]);
      chk("msb_fstart", fs1, e[1]);
      chk("msb_fdone", fd1, e[0]);
      chk("msb_ready", r1, !reset && q1.size() == 0);
    end
  end

  // Present a word and hold it until the model sees it accepted.
  task automatic send(input logic [3:0] d);
    int n0;
    n0 = acc_cnt;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (acc_cnt != n0) return;
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clock);
    #1;
    run = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);

    send(4'b1011);
    idle(7);

    send(4'b1000);
    idle(7);

    send(4'b0001);
    send(4'b1110);
    idle(12);

    send(4'b0101);
    repeat (3) begin
      in_data = 4'($urandom);
      @(posedge clock);
      #1;
    end
    idle(8);

    for (int k = 0; k < 8; k++) begin
      send(4'($urandom));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    idle(8);

    send(4'b1111);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(4);

    send(4'b0110);
    in_valid = 1'b1;
    reset    = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(8);

    chk("drain_lsb", q0.size(), 0);
    chk("drain_msb", q1.size(), 0);
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
